// File: rtl/game_pkg.sv
// Shared GameControl geometry: sprite half-extents, map limits and bullet speeds.
package game_pkg;

  localparam int BULLET_X       = 4;
  localparam int BULLET_Y       = 2;
  localparam int BULLET_STEP_X  = 4;
  localparam int BULLET_STEP_Y  = 1;
  localparam int PLAYER_X       = 16;
  localparam int PLAYER_Y       = 32;
  localparam int SQUAT_PLAYER_Y = 16;
  localparam int MAP_X          = 320;
  localparam int MAP_Y          = 240;

  localparam int unsigned X_W    = 11;
  localparam int unsigned Y_W    = 10;
  localparam int unsigned WIDE_W = 14;

  // Headroom width for all position comparisons so no sum or difference overflows.
  typedef logic signed [WIDE_W-1:0] wide_t;

  function automatic wide_t wide_x(input logic [X_W-1:0] v);
    return {{(WIDE_W-X_W){v[X_W-1]}}, v};
  endfunction

  function automatic wide_t wide_y(input logic [Y_W-1:0] v);
    return {{(WIDE_W-Y_W){v[Y_W-1]}}, v};
  endfunction

endpackage

// File: rtl/enemy_bullet_slot.sv
// One enemy bullet: position registers, per-tick motion, player hit test and retire.
// BULLET_AIM_EN adds a latched vertical direction and vertical motion/retire.
module enemy_bullet_slot
  import game_pkg::*;
#(
  parameter int STEP_X = BULLET_STEP_X
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        load,
  input  logic [10:0] load_x,
  input  logic [9:0]  load_y,
`ifdef BULLET_AIM_EN
  input  logic [1:0]  load_dir,
`endif
  input  logic [10:0] x_player,
  input  logic [9:0]  y_player,
  input  logic        is_q,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        alive,
  output logic        hit_c
);

  localparam wide_t BX     = wide_t'(BULLET_X);
  localparam wide_t BY     = wide_t'(BULLET_Y);
  localparam wide_t PX     = wide_t'(PLAYER_X);
  localparam wide_t PY     = wide_t'(PLAYER_Y);
  localparam wide_t SQ     = wide_t'(SQUAT_PLAYER_Y);
  localparam wide_t X_LIM  = wide_t'(BULLET_X - MAP_X);
`ifdef BULLET_AIM_EN
  localparam wide_t SY     = wide_t'(BULLET_STEP_Y);
  localparam wide_t Y_LIM  = wide_t'(MAP_Y - BULLET_Y);
  localparam wide_t Y_NLIM = wide_t'(BULLET_Y - MAP_Y);

  logic [1:0] dir;
`endif

  logic signed [11:0] xn12;
  wide_t xn_w, yn_w, xp_w, yp_w, h_w;
  logic  hit_x, hit_y, retire;

  // Candidate next position, box overlap against the player, and off-map retire.
  always_comb begin
    xn12 = {x[10], x} - 12'(STEP_X);
    xn_w = {{(WIDE_W-12){xn12[11]}}, xn12};
    yn_w = wide_y(y);
`ifdef BULLET_AIM_EN
    case (dir)
      2'b01:   yn_w = yn_w + SY;
      2'b11:   yn_w = yn_w - SY;
      default: yn_w = yn_w;
    endcase
`endif
    xp_w   = wide_x(x_player);
    yp_w   = wide_y(y_player);
    h_w    = is_q ? SQ : PY;
    hit_x  = (xn_w - BX < xp_w + PX) && (xn_w + BX > xp_w - PX);
    hit_y  = !((yn_w - BY > yp_w + h_w) || (yn_w + BY < yp_w - h_w));
    retire = (xn_w < X_LIM);
`ifdef BULLET_AIM_EN
    retire = retire || (yn_w > Y_LIM) || (yn_w < Y_NLIM);
`endif
    hit_c  = tick && alive && hit_x && hit_y;
  end

  // Slot state: spawn load, advance, or clear on hit/retire; holds between ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alive <= 1'b0;
      x     <= '0;
      y     <= '0;
`ifdef BULLET_AIM_EN
      dir   <= '0;
`endif
    end else if (load) begin
      alive <= 1'b1;
      x     <= load_x;
      y     <= load_y;
`ifdef BULLET_AIM_EN
      dir   <= load_dir;
`endif
    end else if (tick && alive) begin
      if (hit_c || retire) begin
        alive <= 1'b0;
        x     <= '0;
        y     <= '0;
      end else begin
        x <= xn12[10:0];
        y <= yn_w[9:0];
      end
    end
  end

endmodule

// File: rtl/enemy_bullet_pool.sv
// Multi-slot enemy projectile engine: cooldown-gated spawning into the lowest
// free slot, per-tick motion and player collision. BULLET_AIM_EN enables
// vertically aimed bullets.
module enemy_bullet_pool
  import game_pkg::*;
#(
  parameter int N_SLOTS  = 4,
  parameter int COOLDOWN = 16,
  parameter int STEP_X   = BULLET_STEP_X
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                tick,
  input  logic                                attack,
  input  logic                                defend,
  input  logic [10:0]                         xEnemy,
  input  logic [9:0]                          yEnemy,
  input  logic [10:0]                         xPlayer,
  input  logic [9:0]                          yPlayer,
  input  logic                                isQ,
  output logic [N_SLOTS*11-1:0]               x,
  output logic [N_SLOTS*10-1:0]               y,
  output logic [N_SLOTS-1:0]                  alive,
  output logic                                hit,
  output logic [$clog2(N_SLOTS+1)-1:0]        hitCount,
  output logic                                drop
);

  localparam int unsigned CNT_W = $clog2(N_SLOTS + 1);
  localparam int unsigned CD_W  = 16;

  logic [CD_W-1:0]    cd;
  logic               fire;
  logic               any_free;
  logic [N_SLOTS-1:0] load_vec;
  logic [N_SLOTS-1:0] hit_vec;
  logic [CNT_W-1:0]   hit_cnt;
  logic [10:0]        spawn_x;
`ifdef BULLET_AIM_EN
  logic [10:0]        dy;
  logic [1:0]         spawn_dir;

  // Aim direction is the sign of the player's vertical offset at spawn.
  always_comb begin
    dy        = {yPlayer[9], yPlayer} - {yEnemy[9], yEnemy};
    spawn_dir = (dy == '0) ? 2'b00 : (dy[10] ? 2'b11 : 2'b01);
  end
`endif

  assign spawn_x = xEnemy - 11'(PLAYER_X + BULLET_X);
  assign fire    = tick && attack && !defend && (cd == '0);

  // Lowest-index free slot, judged from occupancy before this tick.
  always_comb begin
    any_free = 1'b0;
    load_vec = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (!alive[i] && !any_free) begin
        load_vec[i] = fire;
        any_free    = 1'b1;
      end
    end
  end

  // Number of slots reporting a hit this cycle.
  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      hit_cnt = hit_cnt + CNT_W'(hit_vec[i]);
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_SLOTS; g++) begin : g_slot
      enemy_bullet_slot #(.STEP_X(STEP_X)) u_slot (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .load     (load_vec[g]),
        .load_x   (spawn_x),
        .load_y   (yEnemy),
`ifdef BULLET_AIM_EN
        .load_dir (spawn_dir),
`endif
        .x_player (xPlayer),
        .y_player (yPlayer),
        .is_q     (isQ),
        .x        (x[g*11 +: 11]),
        .y        (y[g*10 +: 10]),
        .alive    (alive[g]),
        .hit_c    (hit_vec[g])
      );
    end
  endgenerate

  // Fire-rate cooldown: reload on an accepted shot, count down on other ticks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cd <= '0;
    end else if (tick) begin
      if (fire && any_free) begin
        cd <= CD_W'(COOLDOWN);
      end else if (cd != '0) begin
        cd <= cd - CD_W'(1);
      end
    end
  end

  // Registered one-cycle event pulses toward health/score logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit      <= 1'b0;
      hitCount <= '0;
      drop     <= 1'b0;
    end else begin
      hit      <= tick && (hit_vec != '0);
      hitCount <= tick ? hit_cnt : '0;
      drop     <= fire && !any_free;
    end
  end

endmodule

// File: tb/tb_enemy_bullet_pool.sv
// Randomized and directed bench for enemy_bullet_pool against a plain-integer model.
module tb_enemy_bullet_pool;
  import game_pkg::*;

  localparam int NS = 3;
  localparam int CD = 2;
  localparam int CW = $clog2(NS + 1);

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              tick = 1'b0;
  logic              attack = 1'b0;
  logic              defend = 1'b0;
  logic [10:0]       xEnemy = '0;
  logic [9:0]        yEnemy = '0;
  logic [10:0]       xPlayer = '0;
  logic [9:0]        yPlayer = '0;
  logic              isQ = 1'b0;
  logic [NS*11-1:0]  x;
  logic [NS*10-1:0]  y;
  logic [NS-1:0]     alive;
  logic              hit;
  logic [CW-1:0]     hitCount;
  logic              drop;

  enemy_bullet_pool #(.N_SLOTS(NS), .COOLDOWN(CD)) dut (
    .clk(clk), .rst(rst), .tick(tick), .attack(attack), .defend(defend),
    .xEnemy(xEnemy), .yEnemy(yEnemy), .xPlayer(xPlayer), .yPlayer(yPlayer),
    .isQ(isQ), .x(x), .y(y), .alive(alive), .hit(hit), .hitCount(hitCount),
    .drop(drop)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  bit m_alive [NS];
  int m_x [NS];
  int m_y [NS];
  int m_dir [NS];
  int m_cd;
  bit e_hit, e_drop;
  int e_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int s11(input int v);
    logic [10:0] t;
    t = v[10:0];
    return int'($signed(t));
  endfunction

  function automatic int s10(input int v);
    logic [9:0] t;
    t = v[9:0];
    return int'($signed(t));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NS; i++) begin
      m_alive[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0;
    end
    m_cd = 0; e_hit = 0; e_drop = 0; e_cnt = 0;
  endtask

  // One frame step from the behavioural rules, using the current inputs.
  task automatic model_tick();
    int fi, xn, yn, hh, xp, yp, xe, ye, hc;
    bit hx, hy, ret;
    xp = int'($signed(xPlayer)); yp = int'($signed(yPlayer));
    xe = int'($signed(xEnemy));  ye = int'($signed(yEnemy));
    hh = isQ ? SQUAT_PLAYER_Y : PLAYER_Y;
    fi = -1;
    for (int i = NS - 1; i >= 0; i--) if (!m_alive[i]) fi = i;
    hc = 0;
    for (int i = 0; i < NS; i++) begin
      if (m_alive[i]) begin
        xn = m_x[i] - BULLET_STEP_X;
        yn = m_y[i];
`ifdef BULLET_AIM_EN
        yn = yn + m_dir[i] * BULLET_STEP_Y;
`endif
        hx = (xn - BULLET_X < xp + PLAYER_X) && (xn + BULLET_X > xp - PLAYER_X);
        hy = !((yn - BULLET_Y > yp + hh) || (yn + BULLET_Y < yp - hh));
        ret = (xn < BULLET_X - MAP_X);
`ifdef BULLET_AIM_EN
        ret = ret || (yn > MAP_Y - BULLET_Y) || (yn < BULLET_Y - MAP_Y);
`endif
        if (hx && hy) begin
          hc++;
          m_alive[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end else if (ret) begin
          m_alive[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end else begin
          m_x[i] = s11(xn); m_y[i] = s10(yn);
        end
      end
    end
    e_drop = 0;
    if (attack && !defend && m_cd == 0) begin
      if (fi >= 0) begin
        m_alive[fi] = 1;
        m_x[fi] = s11(xe - PLAYER_X - BULLET_X);
        m_y[fi] = ye;
        m_dir[fi] = (yp > ye) ? 1 : ((yp < ye) ? -1 : 0);
        m_cd = CD;
      end else begin
        e_drop = 1;
      end
    end else if (m_cd > 0) begin
      m_cd--;
    end
    e_hit = (hc > 0);
    e_cnt = hc;
  endtask

  task automatic check_all();
    for (int i = 0; i < NS; i++) begin
      check($sformatf("alive[%0d]", i), alive[i], m_alive[i]);
      check($sformatf("x[%0d]", i), x[i*11 +: 11], m_x[i][10:0]);
      check($sformatf("y[%0d]", i), y[i*10 +: 10], m_y[i][9:0]);
    end
    check("hit", hit, e_hit);
    check("hitCount", hitCount, e_cnt);
    check("drop", drop, e_drop);
  endtask

  // Inputs are set before the call (at a negedge); returns at the next negedge.
  task automatic cycle(input bit t);
    tick = t;
    if (t) model_tick();
    else begin e_hit = 0; e_drop = 0; e_cnt = 0; end
    @(posedge clk); #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; tick = 1'b0; attack = 1'b0; defend = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic far_player();
    xPlayer = 11'(-1000); yPlayer = 10'(400); isQ = 1'b0;
  endtask

  int drop_at;
  bit seen;

  initial begin
    model_reset();
    far_player();
    do_reset();

    // Idle ticks with no attack.
    for (int i = 0; i < 5; i++) cycle(1);

    // Single shot and first step.
    xEnemy = 11'(200); yEnemy = 10'(0); attack = 1'b1;
    cycle(1);
    check("shot_x", x[10:0], 11'(200 - PLAYER_X - BULLET_X));
    attack = 1'b0;
    cycle(1);
    check("step_x", x[10:0], 11'(200 - PLAYER_X - BULLET_X - BULLET_STEP_X));
    cycle(0);
    cycle(0);

    // Hit on a standing player.
    do_reset();
    xPlayer = 11'(-100); yPlayer = 10'(0); isQ = 1'b0;
    xEnemy = 11'(-40); yEnemy = 10'(0); attack = 1'b1;
    cycle(1);
    attack = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1);
      if (hit) seen = 1;
    end
    check("hit_seen", seen, 1);

    // Bullet passes over the squat hitbox.
    do_reset();
    isQ = 1'b1; yEnemy = 10'(PLAYER_Y); attack = 1'b1;
    cycle(1);
    attack = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1);
      if (hit) seen = 1;
    end
`ifndef BULLET_AIM_EN
    check("squat_miss", seen, 0);
`endif

    // Cooldown and overflow: spawns every CD+1 ticks until slots run out.
    do_reset();
    far_player();
    xEnemy = 11'(900); yEnemy = 10'(0); attack = 1'b1;
    drop_at = -1;
    for (int i = 0; i < 10; i++) begin
      cycle(1);
      if (drop && drop_at < 0) drop_at = i;
    end
    check("drop_tick", drop_at, 3 * (CD + 1));
    check("full", alive, 3'b111);
    attack = 1'b0;

    // Defend suppresses fire and leaves cooldown at zero.
    do_reset();
    attack = 1'b1; defend = 1'b1;
    for (int i = 0; i < 10; i++) cycle(1);
    check("defend_none", alive, 0);
    defend = 1'b0;
    cycle(1);
    check("defend_release", alive, 3'b001);
    attack = 1'b0;

    // Asynchronous reset mid-flight.
    do_reset();
    attack = 1'b1;
    for (int i = 0; i < 7; i++) cycle(1);
    check("three_alive", alive, 3'b111);
    attack = 1'b0;
    cycle(0);
    do_reset();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      attack  = ($urandom_range(0, 99) < 60);
      defend  = ($urandom_range(0, 99) < 20);
      isQ     = $urandom_range(0, 1);
      xPlayer = 11'(int'($urandom_range(0, 600)) - 300);
      yPlayer = 10'(int'($urandom_range(0, 400)) - 200);
      xEnemy  = 11'(int'($urandom_range(0, 1150)) - 250);
      yEnemy  = 10'(int'($urandom_range(0, 400)) - 200);
      cycle($urandom_range(0, 99) < 75);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
